// File: rtl/keypad_pkg.sv
// Shared types and helpers for the matrix keypad front end and its display consumers.
package keypad_pkg;

  localparam int unsigned KeyMaxW = 8;

  // Key codes travel with a separate valid bit so "no key" never aliases code 0.
  typedef struct packed {
    logic               vld;
    logic [KeyMaxW-1:0] code;
  } key_t;

  localparam key_t KeyNone = '{vld: 1'b0, code: '0};

  function automatic int unsigned key_width(input int unsigned rows, input int unsigned cols);
    return (rows * cols > 1) ? $clog2(rows * cols) : 1;
  endfunction

  // ASCII legend of the classic 4x4 telephone-style keypad, indexed by row*4+col.
  function automatic logic [7:0] legend4x4(input logic [3:0] code);
    logic [7:0] ch;
    unique case (code)
      4'd0:  ch = "1";
      4'd1:  ch = "2";
      4'd2:  ch = "3";
      4'd3:  ch = "A";
      4'd4:  ch = "4";
      4'd5:  ch = "5";
      4'd6:  ch = "6";
      4'd7:  ch = "B";
      4'd8:  ch = "7";
      4'd9:  ch = "8";
      4'd10: ch = "9";
      4'd11: ch = "C";
      4'd12: ch = "E";
      4'd13: ch = "0";
      4'd14: ch = "F";
      default: ch = "D";
    endcase
    return ch;
  endfunction

endpackage

// File: rtl/key_fifo.sv
// Show-ahead synchronous FIFO with occupancy count; head is visible whenever not empty.
module key_fifo #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == (AW + 1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_data  = o_empty ? '0 : r_mem[r_rd];

  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign w_pop  = i_pop && !o_empty;
  assign w_push = i_push && (!o_full || w_pop);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
    end
  end

endmodule

// File: rtl/keypad_scan_fifo.sv
// Matrix keypad scanner: one-cold row strobe, per-frame debounce with ghost rejection,
// optional typematic repeat, and a show-ahead key FIFO with sticky overflow.
module keypad_scan_fifo
  import keypad_pkg::*;
#(
  parameter int unsigned ROWS         = 4,
  parameter int unsigned COLS         = 4,
  parameter int unsigned SCAN_DIV     = 65536,
  parameter int unsigned DEBOUNCE     = 12,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter int unsigned REPEAT_EN    = 0,
  parameter int unsigned REPEAT_DELAY = 64,
  parameter int unsigned REPEAT_RATE  = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  output logic [ROWS-1:0]                   row_drive,
  input  logic [COLS-1:0]                   col_sense,
  output logic [key_width(ROWS, COLS)-1:0]  key_data,
  output logic                              key_valid,
  input  logic                              key_ready,
  output logic [$clog2(FIFO_DEPTH):0]       fifo_count,
  output logic                              overflow,
  input  logic                              clr_overflow
);

  localparam int unsigned KW     = key_width(ROWS, COLS);
  localparam int unsigned DivW   = $clog2(SCAN_DIV);
  localparam int unsigned RowW   = $clog2(ROWS);
  localparam int unsigned DbW    = $clog2(DEBOUNCE + 1);
  localparam int unsigned RepMax = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned RepW   = $clog2(RepMax + 1);

  logic [COLS-1:0]    r_col_s1, r_col_s2;
  logic [DivW-1:0]    r_div;
  logic [RowW-1:0]    r_row;
  logic               r_hit, r_multi;
  logic [KeyMaxW-1:0] r_acc_code;
  key_t               r_cand, r_stable;
  logic [DbW-1:0]     r_db_cnt;
  logic [RepW-1:0]    r_rep_cnt;
  logic               r_armed;
  logic               r_push;
  logic [KW-1:0]      r_push_code;
  logic               r_overflow;

  logic               w_tick, w_frame_end;
  logic [COLS-1:0]    w_pressed;
  logic [KeyMaxW-1:0] w_row_col, w_code_n;
  logic               w_any, w_multi, w_hit_n, w_multi_n;
  key_t               w_result, w_cand_d, w_stable_d;
  logic [DbW-1:0]     w_cnt_d;
  logic [RepW-1:0]    w_rep_d;
  logic               w_armed_d, w_push;
  logic               w_full, w_empty, w_pop, w_drop;

  assign w_tick      = (r_div == DivW'(SCAN_DIV - 1));
  assign w_frame_end = w_tick && (r_row == RowW'(ROWS - 1));

  always_comb begin
    row_drive        = '1;
    row_drive[r_row] = 1'b0;
  end

  // Frame accumulator: any second low column, in this row or an earlier one, voids the frame.
  always_comb begin
    w_pressed = ~r_col_s2;
    w_row_col = '0;
    for (int c = 0; c < COLS; c++) begin
      if (w_pressed[c]) w_row_col = KeyMaxW'(c);
    end
    w_any     = |w_pressed;
    w_multi   = |(w_pressed & (w_pressed - 1'b1));
    w_hit_n   = r_hit | w_any;
    w_multi_n = r_multi | w_multi | (r_hit & w_any);
    w_code_n  = (w_any && !r_hit) ? KeyMaxW'(r_row) * KeyMaxW'(COLS) + w_row_col : r_acc_code;
    w_result  = KeyNone;
    if (w_hit_n && !w_multi_n) w_result = '{vld: 1'b1, code: w_code_n};
  end

  always_comb begin
    w_cand_d   = r_cand;
    w_cnt_d    = r_db_cnt;
    w_stable_d = r_stable;
    w_rep_d    = r_rep_cnt;
    w_armed_d  = r_armed;
    w_push     = 1'b0;
    if (w_frame_end) begin
      if (w_result != r_cand) begin
        w_cand_d = w_result;
        w_cnt_d  = DbW'(1);
      end else if (r_db_cnt != DbW'(DEBOUNCE)) begin
        w_cnt_d = r_db_cnt + 1'b1;
      end
      if (w_cnt_d == DbW'(DEBOUNCE) && w_cand_d != r_stable) w_stable_d = w_cand_d;

      if (w_stable_d != r_stable) begin
        w_rep_d   = '0;
        w_armed_d = 1'b0;
        w_push    = w_stable_d.vld;
      end else if (REPEAT_EN != 0 && r_stable.vld && w_result == r_stable) begin
        w_rep_d = r_rep_cnt + 1'b1;
        if (w_rep_d == (r_armed ? RepW'(REPEAT_RATE) : RepW'(REPEAT_DELAY))) begin
          w_push    = 1'b1;
          w_rep_d   = '0;
          w_armed_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col_s1    <= '1;
      r_col_s2    <= '1;
      r_div       <= '0;
      r_row       <= '0;
      r_hit       <= 1'b0;
      r_multi     <= 1'b0;
      r_acc_code  <= '0;
      r_cand      <= KeyNone;
      r_stable    <= KeyNone;
      r_db_cnt    <= '0;
      r_rep_cnt   <= '0;
      r_armed     <= 1'b0;
      r_push      <= 1'b0;
      r_push_code <= '0;
      r_overflow  <= 1'b0;
    end else begin
      r_col_s1 <= col_sense;
      r_col_s2 <= r_col_s1;
      if (w_tick) begin
        r_div      <= '0;
        r_row      <= w_frame_end ? '0 : r_row + 1'b1;
        r_hit      <= w_frame_end ? 1'b0 : w_hit_n;
        r_multi    <= w_frame_end ? 1'b0 : w_multi_n;
        r_acc_code <= w_frame_end ? '0 : w_code_n;
      end else begin
        r_div <= r_div + 1'b1;
      end
      r_cand      <= w_cand_d;
      r_db_cnt    <= w_cnt_d;
      r_stable    <= w_stable_d;
      r_rep_cnt   <= w_rep_d;
      r_armed     <= w_armed_d;
      r_push      <= w_push;
      r_push_code <= w_stable_d.code[KW-1:0];
      // A drop in the same cycle as the clear keeps the flag set.
      if (w_drop)            r_overflow <= 1'b1;
      else if (clr_overflow) r_overflow <= 1'b0;
    end
  end

  assign key_valid = !w_empty;
  assign w_pop     = key_valid && key_ready;
  assign w_drop    = r_push && w_full && !w_pop;
  assign overflow  = r_overflow;

  key_fifo #(
    .WIDTH (KW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (r_push),
    .i_data  (r_push_code),
    .i_pop   (w_pop),
    .o_data  (key_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (fifo_count)
  );

endmodule
